// File: rtl/gpio_pkg.sv
// gpio_pkg -- shared constants and types for the gpio_ctrl block.
//
// Contents:
//   gpio_reg_idx_t   register index, taken from addr[4:2]
//   GPIO_*_OFS       word index of each register (byte offset / 4)
//   GPIO_MAX_W       widest supported pin count (one bus word)
package gpio_pkg;

    localparam int GPIO_MAX_W = 32;

    typedef logic [2:0] gpio_reg_idx_t;

    localparam gpio_reg_idx_t GPIO_OUT_OFS  = 3'd0;  // 0x00 OUT
    localparam gpio_reg_idx_t GPIO_DIR_OFS  = 3'd1;  // 0x04 DIR
    localparam gpio_reg_idx_t GPIO_IN_OFS   = 3'd2;  // 0x08 IN
    localparam gpio_reg_idx_t GPIO_EN_OFS   = 3'd3;  // 0x0C IRQ_EN
    localparam gpio_reg_idx_t GPIO_RISE_OFS = 3'd4;  // 0x10 IRQ_RISE
    localparam gpio_reg_idx_t GPIO_STAT_OFS = 3'd5;  // 0x14 IRQ_STAT

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync -- per-bit flop chain that brings asynchronous pin levels into
// the clk domain. Every stage resets to 0.
//
// Ports:
//   clk   in  1  system clock
//   rstn  in  1  asynchronous active-low reset
//   d_i   in  W  asynchronous inputs
//   q_o   out W  synchronised outputs (last stage of the chain)
module gpio_sync #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] chain_q [STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl -- memory-mapped GPIO controller: output data, direction,
// synchronised input readback and per-pin edge interrupts with W1C status.
//
// Configuration macro: GPIO_IRQ_EN
//   defined   -> IRQ_EN / IRQ_RISE / IRQ_STAT, edge detector and arming
//                counter are built; irq is live.
//   undefined -> those registers read 0 and ignore writes, irq is tied 0.
//
// Parameters: GPIO_W (1..32) pin count, SYNC_STAGES (2..4) synchroniser depth.
//
// Ports:
//   clk      in  1       system clock (rising edge)
//   rstn     in  1       asynchronous active-low reset
//   sel      in  1       block select from the top-level decoder
//   rd       in  1       read strobe (qualified by sel)
//   wr       in  1       write strobe (qualified by sel)
//   addr     in  8       byte address; addr[4:2] picks the register
//   wdata    in  32      write data
//   rdata    out 32      registered read data
//   gpio_i   in  GPIO_W  asynchronous pin inputs
//   gpio_o   out GPIO_W  pin output values
//   gpio_oe  out GPIO_W  pin output enables (1 = drive)
//   irq      out 1       registered level interrupt
//
// Bus semantics: there is no valid/ready pair; the block is always ready.
// A transfer is accepted on every rising edge where sel is high. sel&wr
// updates the addressed register on that edge; sel&rd loads rdata on that
// edge with the register value seen before the edge (so rd+wr together is a
// write whose rdata shows the pre-write value). Without sel&rd, rdata holds.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int GPIO_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sel,
    input  logic              rd,
    input  logic              wr,
    input  logic [7:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);

    gpio_reg_idx_t reg_idx;
    logic          wr_en;
    logic          rd_en;

    assign reg_idx = addr[4:2];
    assign wr_en   = sel & wr;
    assign rd_en   = sel & rd;

    // Address bits outside addr[4:2] and wdata bits above GPIO_W carry no
    // meaning for this block.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{addr[7:5], addr[1:0], wdata};

    logic [GPIO_W-1:0] out_q, out_d;
    logic [GPIO_W-1:0] dir_q, dir_d;
    logic [GPIO_W-1:0] in_sync;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       rd_val;

    gpio_sync #(
        .W      (GPIO_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (gpio_i),
        .q_o  (in_sync)
    );

`ifdef GPIO_IRQ_EN
    // Edge detection stays off until the synchroniser chain and the delayed
    // copy have both been loaded from real pin values; otherwise pins held
    // high through reset would look like a rising edge.
    localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES + 1);

    logic [GPIO_W-1:0] en_q, en_d;
    logic [GPIO_W-1:0] rise_q, rise_d;
    logic [GPIO_W-1:0] stat_q, stat_d;
    logic [GPIO_W-1:0] in_prev_q, in_prev_d;
    logic [2:0]        arm_cnt_q, arm_cnt_d;
    logic              irq_q, irq_d;
    logic              armed;
    logic [GPIO_W-1:0] edge_ev;
    logic [GPIO_W-1:0] stat_clr;

    always_comb begin
        armed     = (arm_cnt_q == ARM_LAST);
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
        in_prev_d = in_sync;

        edge_ev = '0;
        if (armed) begin
            edge_ev = (in_sync & ~in_prev_q & rise_q) |
                      (~in_sync & in_prev_q & ~rise_q);
        end

        en_d     = en_q;
        rise_d   = rise_q;
        stat_clr = '0;
        if (wr_en) begin
            if (reg_idx == GPIO_EN_OFS)   en_d     = wdata[GPIO_W-1:0];
            if (reg_idx == GPIO_RISE_OFS) rise_d   = wdata[GPIO_W-1:0];
            if (reg_idx == GPIO_STAT_OFS) stat_clr = wdata[GPIO_W-1:0];
        end

        // OR-ing the event in after the clear makes a same-cycle set win.
        stat_d = (stat_q & ~stat_clr) | edge_ev;
        irq_d  = |(stat_q & en_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q      <= '0;
            rise_q    <= '0;
            stat_q    <= '0;
            in_prev_q <= '0;
            arm_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            rise_q    <= rise_d;
            stat_q    <= stat_d;
            in_prev_q <= in_prev_d;
            arm_cnt_q <= arm_cnt_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Read mux: unused upper bits and unmapped offsets return 0.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            GPIO_OUT_OFS:  rd_val[GPIO_W-1:0] = out_q;
            GPIO_DIR_OFS:  rd_val[GPIO_W-1:0] = dir_q;
            GPIO_IN_OFS:   rd_val[GPIO_W-1:0] = in_sync;
`ifdef GPIO_IRQ_EN
            GPIO_EN_OFS:   rd_val[GPIO_W-1:0] = en_q;
            GPIO_RISE_OFS: rd_val[GPIO_W-1:0] = rise_q;
            GPIO_STAT_OFS: rd_val[GPIO_W-1:0] = stat_q;
`endif
            default:       rd_val = '0;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        rdata_d = rdata_q;
        if (wr_en && reg_idx == GPIO_OUT_OFS) out_d = wdata[GPIO_W-1:0];
        if (wr_en && reg_idx == GPIO_DIR_OFS) dir_d = wdata[GPIO_W-1:0];
        if (rd_en)                            rdata_d = rd_val;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q   <= '0;
            dir_q   <= '0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            rdata_q <= rdata_d;
        end
    end

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
    assign rdata   = rdata_q;

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised memory-mapped GPIO controller replacing the single 8-bit write-only output register on the FPGA top level. It sits on the CPU data bus behind the top-level address decoder. It provides per-pin output data and direction, synchronised input readback, and per-pin edge-detect interrupts with write-1-to-clear status. Read data is registered, with the same one-cycle latency as the data RAM.

## Interface
Parameters:
- GPIO_W, 8: number of pins; legal range 1..32.
- SYNC_STAGES, 2: input synchroniser depth; legal range 2..4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- sel  in  1  block selected by the top-level decoder.
- rd  in  1  read strobe; qualified by sel.
- wr  in  1  write strobe; qualified by sel.
- addr  in  8  byte address within the block; addr[4:2] selects the register, addr[1:0] is ignored.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- gpio_i  in  GPIO_W  asynchronous pin inputs.
- gpio_o  out  GPIO_W  pin output values.
- gpio_oe  out  GPIO_W  output enables; 1 = drive.
- irq  out  1  level interrupt to the CPU, registered.

## Operation
Registers, word offsets (bits at or above GPIO_W read 0 and ignore writes):
- 0x00 OUT (RW): drives gpio_o.
- 0x04 DIR (RW): drives gpio_oe.
- 0x08 IN (RO): synchroniser output. Writes are ignored.
- 0x0C IRQ_EN (RW): per-pin interrupt enable.
- 0x10 IRQ_RISE (RW): 1 = rising edge, 0 = falling edge.
- 0x14 IRQ_STAT (W1C): latched edge events. Writing 1 clears a bit; writing 0 has no effect.
- 0x18, 0x1C: unmapped. Reads return 0; writes are ignored.

Behaviour:
- Edge detection compares the synchroniser output with its one-cycle-delayed copy. On a matching edge the IRQ_STAT bit sets whether or not IRQ_EN is set.
- irq is registered: irq <= |(IRQ_STAT & IRQ_EN).
- Arming counter: after reset deassertion, edge detection is suppressed for SYNC_STAGES+1 cycles so the synchroniser can prime. Pins held high through reset therefore never produce a spurious rising event.
- If a set event and a W1C clear hit the same bit in the same cycle, the set wins.
- sel with both rd and wr high is a write. rdata then returns the pre-write value of the addressed register.
- rdata holds its last value when no read is in progress.
- Reset values: gpio_o=0, gpio_oe=0, irq=0, rdata=0, all registers 0, arming counter 0 (disarmed).
- Reset asserted mid-operation clears all state immediately and restarts the arming count.

## Timing
- Write: the register updates on the clk edge where sel&wr is sampled. gpio_o and gpio_oe change in the same cycle.
- Read: sel&rd sampled at edge n; rdata is valid after edge n. There are no wait states, and back-to-back reads are allowed every cycle.
- Input path: a pin change that is stable before edge 1 becomes visible in IN after edge SYNC_STAGES. IRQ_STAT sets after edge SYNC_STAGES+1, and irq asserts after edge SYNC_STAGES+2 (4 edges at the default depth).
- W1C at edge n: the status bit is 0 after edge n, and irq deasserts after edge n+1 unless other enabled bits remain set.

## Configuration
- GPIO_IRQ_EN defined: IRQ_EN, IRQ_RISE, IRQ_STAT, the edge detector and the arming counter are built, and irq behaves as specified above.
- GPIO_IRQ_EN undefined: those registers read 0 and ignore writes, irq is tied to 0, and the synchroniser and IN remain.

## Structure
- gpio_pkg holds the register offset constants (GPIO_OUT_OFS … GPIO_STAT_OFS), the maximum width constant 32, and the register-index typedef.
- One sub-module, gpio_sync: a per-bit SYNC_STAGES flop chain with asynchronous reset to 0, instantiated once at width GPIO_W.

## Test plan
- Reset, then read every offset: all return 0; gpio_o=0, gpio_oe=0, irq=0.
- Write OUT=0xA5 and DIR=0x0F: gpio_o=0xA5 and gpio_oe=0x0F on the following cycle. Reading OUT returns 0x000000A5; writing 0xFFFFFFFF with GPIO_W=8 reads back 0x000000FF.
- Set IRQ_EN=0x01, IRQ_RISE=0x01, drive gpio_i[0] 0→1: IN bit 0 is visible after 2 edges, IRQ_STAT=0x01 after 3, irq=1 after 4. Writing IRQ_STAT=0x01 drops irq 2 edges later.
- With IRQ_RISE[3]=0, a gpio_i[3] falling edge arriving in the same cycle as a W1C of bit 3: bit 3 remains set and irq stays high.
- Hold gpio_i=0xFF through reset release with IRQ_EN=0xFF: no IRQ_STAT bits set and irq stays 0.
- Built without GPIO_IRQ_EN: toggle all pins; irq stays 0, offsets 0x0C–0x14 read 0, and IN tracks the pins.
